// File: rtl/ppi_bus_sequencer.sv
// PPI8255A bus master: timed nCs/nRe/nWr cycles shared round-robin by two requesters.
// Optional build macro PPI_AUTOINIT_EN: write INIT_CW to the control register after reset.
module ppi_bus_sequencer #(
    parameter int         SETUP_CYC  = 1,
    parameter int         STROBE_CYC = 2,
    parameter int         HOLD_CYC   = 1,
    parameter logic [7:0] INIT_CW    = 8'h80
) (
    input  logic       Clk_i,
    input  logic       nReset_i,
    input  logic       Req0_i,
    input  logic       Req1_i,
    input  logic       We0_i,
    input  logic       We1_i,
    input  logic [1:0] Addr0_i,
    input  logic [1:0] Addr1_i,
    input  logic [7:0] WData0_i,
    input  logic [7:0] WData1_i,
    output logic       Ack0_o,
    output logic       Ack1_o,
    output logic [7:0] RData_o,
    output logic       Busy_o,
    output logic [7:0] CwShadow_o,
    output logic       nCs_o,
    output logic       nRe_o,
    output logic       nWr_o,
    output logic [1:0] A_o,
    output logic [7:0] DOut_o,
    output logic       DOe_o,
    input  logic [7:0] DIn_i
);

`ifdef PPI_AUTOINIT_EN
    localparam logic AUTOINIT = 1'b1;
`else
    localparam logic AUTOINIT = 1'b0;
`endif

    localparam logic [7:0] SETUP_L  = 8'(SETUP_CYC);
    localparam logic [7:0] STROBE_L = 8'(STROBE_CYC);
    localparam logic [7:0] HOLD_L   = 8'(HOLD_CYC);
    localparam logic [7:0] RST_CW   = AUTOINIT ? INIT_CW : 8'h9B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       owner_q, owner_d;
    logic       int_q, int_d;
    logic       last_q, last_d;
    logic       init_q, init_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] shadow_q, shadow_d;
    logic       grant1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last
    assign grant1 = Req1_i && (!Req0_i || !last_q);

    assign RData_o    = rdata_q;
    assign CwShadow_o = shadow_q;
    assign Busy_o     = (state_q != S_IDLE) || init_q;

    // State and latched transaction registers; reset drops every strobe at once
    always_ff @(posedge Clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'h00;
            we_q     <= 1'b0;
            addr_q   <= 2'b00;
            wdata_q  <= 8'h00;
            owner_q  <= 1'b0;
            int_q    <= 1'b0;
            last_q   <= 1'b1;
            init_q   <= AUTOINIT;
            rdata_q  <= 8'h00;
            shadow_q <= RST_CW;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            int_q    <= int_d;
            last_q   <= last_d;
            init_q   <= init_d;
            rdata_q  <= rdata_d;
            shadow_q <= shadow_d;
        end
    end

    // Phase sequencing, arbitration and PPI pin decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        int_d    = int_q;
        last_d   = last_q;
        init_d   = init_q;
        rdata_d  = rdata_q;
        shadow_d = shadow_q;
        nCs_o    = 1'b1;
        nRe_o    = 1'b1;
        nWr_o    = 1'b1;
        A_o      = 2'b00;
        DOut_o   = 8'h00;
        DOe_o    = 1'b0;
        Ack0_o   = 1'b0;
        Ack1_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (init_q) begin
                    we_d    = 1'b1;
                    addr_d  = 2'b11;
                    wdata_d = INIT_CW;
                    int_d   = 1'b1;
                    init_d  = 1'b0;
                    cnt_d   = SETUP_L;
                    state_d = S_SETUP;
                end else if (Req0_i || Req1_i) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    int_d   = 1'b0;
                    we_d    = grant1 ? We1_i : We0_i;
                    addr_d  = grant1 ? Addr1_i : Addr0_i;
                    wdata_d = grant1 ? WData1_i : WData0_i;
                    cnt_d   = SETUP_L;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                nCs_o  = 1'b0;
                A_o    = addr_q;
                DOe_o  = we_q;
                DOut_o = we_q ? wdata_q : 8'h00;
                if (cnt_q == 8'd1) begin
                    cnt_d   = STROBE_L;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STROBE: begin
                nCs_o  = 1'b0;
                A_o    = addr_q;
                DOe_o  = we_q;
                DOut_o = we_q ? wdata_q : 8'h00;
                nWr_o  = !we_q;
                nRe_o  = we_q;
                if (cnt_q == 8'd1) begin
                    if (!we_q) begin
                        rdata_d = DIn_i;
                    end
                    cnt_d   = HOLD_L;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                nCs_o  = 1'b0;
                A_o    = addr_q;
                DOe_o  = we_q;
                DOut_o = we_q ? wdata_q : 8'h00;
                if (cnt_q == 8'd1) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                Ack0_o = !int_q && !owner_q;
                Ack1_o = !int_q && owner_q;
                if (we_q && (addr_q == 2'b11) && wdata_q[7]) begin
                    shadow_d = wdata_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Bench for ppi_bus_sequencer: directed cases plus randomized rounds
// checked against a transaction-level model of timing, arbitration and shadow.
module tb_ppi_bus_sequencer;

    localparam int         SC  = 1;
    localparam int         STC = 2;
    localparam int         HC  = 1;
    localparam int         T   = SC + STC + HC;
    localparam logic [7:0] ICW = 8'h9B;
`ifdef PPI_AUTOINIT_EN
    localparam logic [7:0] RST_CW = ICW;
    localparam logic       AI     = 1'b1;
`else
    localparam logic [7:0] RST_CW = 8'h9B;
    localparam logic       AI     = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] cw;
    logic       ncs, nre, nwr;
    logic [1:0] a_pin;
    logic [7:0] dout;
    logic       doe;
    logic [7:0] din;

    int tests = 0;
    int fails = 0;

    int         m_last;
    logic [7:0] m_shadow;
    logic [7:0] m_rdata;
    logic       f_we[2];
    logic [1:0] f_ad[2];
    logic [7:0] f_wd[2];

    always #5 clk = ~clk;

    ppi_bus_sequencer #(
        .SETUP_CYC (SC),
        .STROBE_CYC(STC),
        .HOLD_CYC  (HC),
        .INIT_CW   (ICW)
    ) dut (
        .Clk_i     (clk),
        .nReset_i  (rst_n),
        .Req0_i    (req0),
        .Req1_i    (req1),
        .We0_i     (we0),
        .We1_i     (we1),
        .Addr0_i   (addr0),
        .Addr1_i   (addr1),
        .WData0_i  (wdata0),
        .WData1_i  (wdata1),
        .Ack0_o    (ack0),
        .Ack1_o    (ack1),
        .RData_o   (rdata),
        .Busy_o    (busy),
        .CwShadow_o(cw),
        .nCs_o     (ncs),
        .nRe_o     (nre),
        .nWr_o     (nwr),
        .A_o       (a_pin),
        .DOut_o    (dout),
        .DOe_o     (doe),
        .DIn_i     (din)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fields();
        we0    = f_we[0];
        we1    = f_we[1];
        addr0  = f_ad[0];
        addr1  = f_ad[1];
        wdata0 = f_wd[0];
        wdata1 = f_wd[1];
    endtask

    // Watch the bus until one Ack, counting pin activity per negedge
    task automatic serve(input bit hold, output int who, output int lat,
                         output int n_cs, output int n_wr, output int n_re,
                         output int n_oe, output logic [7:0] d_seen,
                         output logic [1:0] a_seen, output logic [7:0] rd);
        who    = -1;
        lat    = 0;
        n_cs   = 0;
        n_wr   = 0;
        n_re   = 0;
        n_oe   = 0;
        d_seen = 'x;
        a_seen = 'x;
        rd     = 'x;
        for (int k = 1; k <= 30 && who < 0; k++) begin
            @(negedge clk);
            if (!ncs) begin
                n_cs++;
                a_seen = a_pin;
            end
            if (!nwr) begin
                n_wr++;
                d_seen = dout;
            end
            if (!nre) n_re++;
            if (doe) n_oe++;
            if (ack0 || ack1) begin
                who = ack1 ? 1 : 0;
                lat = k;
                rd  = rdata;
                if (!hold) begin
                    if (ack1) req1 = 1'b0;
                    else req0 = 1'b0;
                end
            end
        end
    endtask

    // Issue requests at an IDLE negedge and check n served transactions
    task automatic txn_round(input bit r0, input bit r1, input int n,
                             input bit hold);
        bit         pend[2];
        int         g, who, lat, n_cs, n_wr, n_re, n_oe;
        logic [7:0] d_seen, rd;
        logic [1:0] a_seen;
        pend[0] = r0;
        pend[1] = r1;
        drive_fields();
        req0 = r0;
        req1 = r1;
        for (int i = 0; i < n; i++) begin
            if (pend[0] && pend[1]) g = (m_last == 1) ? 0 : 1;
            else g = pend[0] ? 0 : 1;
            m_last = g;
            serve(hold, who, lat, n_cs, n_wr, n_re, n_oe, d_seen, a_seen, rd);
            if (i == n - 1) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (!hold) pend[g] = 1'b0;
            chk("owner", who, g);
            chk("latency", lat, T + 1);
            chk("ncs_low", n_cs, T);
            chk("nwr_low", n_wr, f_we[g] ? STC : 0);
            chk("nre_low", n_re, f_we[g] ? 0 : STC);
            chk("doe_cyc", n_oe, f_we[g] ? T : 0);
            chk("addr", a_seen, f_ad[g]);
            if (f_we[g]) chk("dout", d_seen, f_wd[g]);
            else m_rdata = din;
            chk("rdata", rd, m_rdata);
            if (f_we[g] && f_ad[g] == 2'b11 && f_wd[g][7]) m_shadow = f_wd[g];
            @(negedge clk);
            chk("gap_ncs", ncs, 1);
            chk("gap_busy", busy, 0);
            chk("shadow", cw, m_shadow);
        end
    endtask

`ifdef PPI_AUTOINIT_EN
    task automatic wait_init();
        for (int k = 0; k < 30 && busy; k++) @(negedge clk);
        chk("init_done", busy, 0);
    endtask
`endif

    initial begin
        int         acks;
        int         r;
        int         who, lat, n_cs, n_wr, n_re, n_oe;
        logic [7:0] d_seen, rd;
        logic [1:0] a_seen;

        rst_n  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        din    = 8'h00;
        m_last = 1;
        m_shadow = RST_CW;
        m_rdata  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            f_we[i] = 1'b0;
            f_ad[i] = 2'b00;
            f_wd[i] = 8'h00;
        end
        drive_fields();
        #12;
        chk("rst_ncs", ncs, 1);
        chk("rst_nre", nre, 1);
        chk("rst_nwr", nwr, 1);
        chk("rst_a", a_pin, 0);
        chk("rst_dout", dout, 0);
        chk("rst_doe", doe, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, AI);
        chk("rst_shadow", cw, RST_CW);

`ifdef PPI_AUTOINIT_EN
        f_ad[0] = 2'b01;
        drive_fields();
        din  = 8'h3C;
        req0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_busy", busy, 1);
        serve(1'b0, who, lat, n_cs, n_wr, n_re, n_oe, d_seen, a_seen, rd);
        chk("init_owner", who, 0);
        chk("init_lat", lat, 2 * T + 2);
        chk("init_ncs", n_cs, 2 * T - 1);
        chk("init_nwr", n_wr, STC);
        chk("init_nre", n_re, STC);
        chk("init_dout", d_seen, ICW);
        chk("init_rdata", rd, 8'h3C);
        m_last  = 0;
        m_rdata = 8'h3C;
        @(negedge clk);
        chk("init_shadow", cw, ICW);
`else
        @(negedge clk);
        rst_n = 1'b1;
`endif

        f_we[0] = 1'b1;
        f_ad[0] = 2'b11;
        f_wd[0] = 8'h89;
        txn_round(1'b1, 1'b0, 1, 1'b0);

        f_we[1] = 1'b0;
        f_ad[1] = 2'b00;
        din     = 8'h5A;
        txn_round(1'b0, 1'b1, 1, 1'b0);

        f_wd[0] = 8'h07;
        txn_round(1'b1, 1'b0, 1, 1'b0);
        chk("bsr_keeps_cw", cw, 8'h89);

        f_we[0] = 1'b1;
        f_ad[0] = 2'b10;
        f_wd[0] = 8'hC3;
        f_we[1] = 1'b0;
        f_ad[1] = 2'b01;
        din     = 8'hE1;
        txn_round(1'b1, 1'b1, 4, 1'b1);

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++) begin
                f_we[i] = 1'($urandom);
                f_ad[i] = 2'($urandom);
                f_wd[i] = 8'($urandom);
            end
            din = 8'($urandom);
            txn_round(r[0], r[1], int'(r[0]) + int'(r[1]), 1'b0);
        end

        f_we[0] = 1'b1;
        f_ad[0] = 2'b01;
        f_wd[0] = 8'hA5;
        drive_fields();
        req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_nwr_low", nwr, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ncs", ncs, 1);
        chk("mid_nwr", nwr, 1);
        chk("mid_nre", nre, 1);
        chk("mid_doe", doe, 0);
        chk("mid_busy", busy, AI);
        req0 = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        rst_n    = 1'b1;
        m_last   = 1;
        m_shadow = RST_CW;
        m_rdata  = 8'h00;
`ifdef PPI_AUTOINIT_EN
        wait_init();
`endif
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("no_ack_after_rst", acks, 0);
        chk("post_rst_shadow", cw, RST_CW);

        for (int i = 0; i < 2; i++) begin
            f_we[i] = 1'b0;
            f_ad[i] = 2'(i + 1);
        end
        din = 8'h6D;
        txn_round(1'b1, 1'b1, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
